// File: rtl/cam_pkg.sv
// Shared types and constants for the camera frame writer.
// cam_rgb565_to_rgb332 is used when CAM_RGB332_EN is defined.
package cam_pkg;

    localparam int unsigned CAM_H_ACT_DEF = 160;
    localparam int unsigned CAM_V_ACT_DEF = 120;
    localparam int unsigned CAM_PIX_W     = 16;

    typedef enum logic [1:0] {
        ST_SYNC  = 2'd0,
        ST_FRAME = 2'd1,
        ST_HI    = 2'd2,
        ST_LO    = 2'd3
    } cam_state_e;

    // One capture-FIFO word as delivered by the sensor front end.
    typedef struct packed {
        logic       vsync;
        logic       href;
        logic [7:0] data;
    } cam_word_t;

    // Keep R[4:2], G[5:3], B[4:3] of an RGB565 pixel, zero-extended to 16 bits.
    function automatic logic [CAM_PIX_W-1:0] cam_rgb565_to_rgb332(input logic [CAM_PIX_W-1:0] p);
        return {8'h00, p[15:13], p[10:8], p[4:3]};
    endfunction

endpackage

// File: rtl/cam_pix_fmt.sv
// Pixel format stage: passes {hi, lo} through, or reduces it to RGB332
// when CAM_RGB332_EN is defined. Purely combinational, so timing is build-independent.
module cam_pix_fmt
    import cam_pkg::*;
(
    input  logic [7:0]           hi,
    input  logic [7:0]           lo,
    output logic [CAM_PIX_W-1:0] pix_c
);

`ifdef CAM_RGB332_EN
    assign pix_c = cam_rgb565_to_rgb332({hi, lo});
`else
    assign pix_c = {hi, lo};
`endif

endmodule

// File: rtl/cam_frame_writer.sv
// Turns a camera capture stream into frame-buffer pixel writes at y*H_ACT+x.
// Optional build macro: CAM_RGB332_EN (RGB332 output packing).
module cam_frame_writer
    import cam_pkg::*;
#(
    parameter int unsigned H_ACT  = CAM_H_ACT_DEF,
    parameter int unsigned V_ACT  = CAM_V_ACT_DEF,
    parameter int unsigned ADDR_W = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [9:0]        fifo_data,
    input  logic              fifo_empty,
    output logic              fifo_rd,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [15:0]       wr_data,
    output logic              frame_done,
    output logic              err
);

    localparam int unsigned X_W = $clog2(H_ACT + 1);
    localparam int unsigned Y_W = $clog2(V_ACT + 1);
    localparam logic [X_W-1:0] X_LIM  = X_W'(H_ACT);
    localparam logic [Y_W-1:0] Y_LIM  = Y_W'(V_ACT);
    localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_ACT - 1);

    cam_state_e          state;
    cam_word_t           word;
    logic                word_vld;
    logic [7:0]          hi;
    logic [X_W-1:0]      x;
    logic [Y_W-1:0]      y;
    logic [ADDR_W-1:0]   addr;
    logic [ADDR_W-1:0]   eol_addr_c;
    logic [15:0]         pix_c;

    assign word    = cam_word_t'(fifo_data);
    assign fifo_rd = !fifo_empty && !reset;

    // Next line starts at (y+1)*H_ACT no matter how many pixels this line wrote.
    assign eol_addr_c = (y == Y_LAST) ? addr : addr + ADDR_W'(H_ACT - 32'(x));

    cam_pix_fmt u_pix_fmt (
        .hi    (hi),
        .lo    (word.data),
        .pix_c (pix_c)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= ST_SYNC;
            word_vld   <= 1'b0;
            hi         <= '0;
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
            err        <= 1'b0;
        end else begin
            word_vld   <= fifo_rd;
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (word_vld) begin
                case (state)
                    ST_SYNC: begin
                        if (word.vsync) begin
                            state <= ST_FRAME;
                            x     <= '0;
                            y     <= '0;
                            addr  <= '0;
                        end
                    end
                    // Lines past V_ACT stay here and are silently consumed.
                    ST_FRAME: begin
                        if (word.vsync) begin
                            frame_done <= (y != '0);
                            x          <= '0;
                            y          <= '0;
                            addr       <= '0;
                        end else if (word.href && (y < Y_LIM)) begin
                            hi    <= word.data;
                            state <= ST_LO;
                        end
                    end
                    ST_LO: begin
                        if (word.vsync) begin
                            err   <= 1'b1;
                            x     <= '0;
                            y     <= '0;
                            addr  <= '0;
                            state <= ST_FRAME;
                        end else if (word.href) begin
                            if (x < X_LIM) begin
                                wr_en   <= 1'b1;
                                wr_addr <= addr;
                                wr_data <= pix_c;
                                addr    <= addr + ADDR_W'(1);
                                x       <= x + X_W'(1);
                            end else begin
                                err <= 1'b1;
                            end
                            state <= ST_HI;
                        end else begin
                            err   <= 1'b1;
                            addr  <= eol_addr_c;
                            x     <= '0;
                            y     <= y + Y_W'(1);
                            state <= ST_FRAME;
                        end
                    end
                    ST_HI: begin
                        if (word.vsync) begin
                            err   <= 1'b1;
                            x     <= '0;
                            y     <= '0;
                            addr  <= '0;
                            state <= ST_FRAME;
                        end else if (word.href) begin
                            hi    <= word.data;
                            state <= ST_LO;
                        end else begin
                            addr  <= eol_addr_c;
                            x     <= '0;
                            y     <= y + Y_W'(1);
                            state <= ST_FRAME;
                        end
                    end
                    default: state <= ST_SYNC;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_cam_frame_writer.sv
// Directed bench for cam_frame_writer with a 4x2 frame and a queue-backed capture FIFO.
module tb_cam_frame_writer;

    localparam int H  = 4;
    localparam int V  = 2;
    localparam int AW = 3;

    logic          clk = 1'b0;
    logic          reset;
    logic [9:0]    fifo_data = '0;
    logic          fifo_empty = 1'b1;
    logic          fifo_rd;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0]   wr_data;
    logic          frame_done;
    logic          err;

    logic [10:0]   q[$];
    logic [AW-1:0] got_a[$];
    logic [15:0]   got_d[$];
    int            got_cyc[$];
    logic [AW-1:0] ex_a[$];
    logic [15:0]   ex_d[$];
    int            cyc = 0;
    int            mark_cyc = -1;
    int            fd_cnt = 0;
    int            n_cmp = 0;
    int            n_bad = 0;

    always #5 clk = ~clk;

    cam_frame_writer #(.H_ACT(H), .V_ACT(V), .ADDR_W(AW)) dut (
        .clk        (clk),
        .reset      (reset),
        .fifo_data  (fifo_data),
        .fifo_empty (fifo_empty),
        .fifo_rd    (fifo_rd),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .frame_done (frame_done),
        .err        (err)
    );

    // Capture FIFO model: popped word appears on fifo_data the cycle after fifo_rd.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (fifo_rd && q.size() > 0) begin
            logic [10:0] w;
            w = q.pop_front();
            fifo_data <= w[9:0];
            if (w[10]) mark_cyc <= cyc + 2;
        end
    end

    always @(negedge clk) fifo_empty = (q.size() == 0);

    always @(negedge clk) begin
        if (!reset) begin
            if (wr_en) begin
                got_a.push_back(wr_addr);
                got_d.push_back(wr_data);
                got_cyc.push_back(cyc);
            end
            if (frame_done) fd_cnt++;
        end
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] exp_pix(input logic [7:0] h, input logic [7:0] l);
`ifdef CAM_RGB332_EN
        return {8'h00, h[7:5], h[2:0], l[4:3]};
`else
        return {h, l};
`endif
    endfunction

    task automatic push(input bit mark, input bit vs, input bit hr, input logic [7:0] b);
        q.push_back({mark, vs, hr, b});
    endtask

    task automatic vs_words(input int n);
        repeat (n) push(1'b0, 1'b1, 1'b0, 8'h00);
    endtask

    task automatic line(input int a0, input int npix, input bit odd, input logic [7:0] base,
                        input bit wr, input bit mark, input int nblank);
        for (int i = 0; i < npix; i++) begin
            logic [7:0] h;
            logic [7:0] l;
            h = base + 8'(i);
            l = 8'h0F + 8'(3 * i);
            push(1'b0, 1'b0, 1'b1, h);
            push(mark && (i == 0), 1'b0, 1'b1, l);
            if (wr && i < H) begin
                ex_a.push_back(AW'(a0 + i));
                ex_d.push_back(exp_pix(h, l));
            end
        end
        if (odd) push(1'b0, 1'b0, 1'b1, base ^ 8'h55);
        repeat (nblank) push(1'b0, 1'b0, 1'b0, 8'h00);
    endtask

    task automatic clear_capture();
        got_a.delete(); got_d.delete(); got_cyc.delete();
        ex_a.delete();  ex_d.delete();
        fd_cnt   = 0;
        mark_cyc = -1;
    endtask

    task automatic do_reset(input string t);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk); #1;
        check({t, "_rst_wr_en"},  32'(wr_en), 0);
        check({t, "_rst_addr"},   32'(wr_addr), 0);
        check({t, "_rst_data"},   32'(wr_data), 0);
        check({t, "_rst_fdone"},  32'(frame_done), 0);
        check({t, "_rst_err"},    32'(err), 0);
        check({t, "_rst_fifo_rd"}, 32'(fifo_rd), 0);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_capture();
    endtask

    task automatic drain(input string t);
        int n;
        n = 0;
        while (q.size() > 0 && n < 2000) begin
            @(posedge clk);
            n++;
        end
        check({t, "_drain_left"}, 32'(q.size()), 0);
        repeat (4) @(posedge clk);
        @(negedge clk); #1;
    endtask

    task automatic compare(input string t, input int exp_fd, input bit exp_err);
        check({t, "_nwr"}, 32'(got_a.size()), 32'(ex_a.size()));
        for (int i = 0; i < got_a.size() && i < ex_a.size(); i++) begin
            check($sformatf("%s_addr%0d", t, i), 32'(got_a[i]), 32'(ex_a[i]));
            check($sformatf("%s_data%0d", t, i), 32'(got_d[i]), 32'(ex_d[i]));
        end
        check({t, "_frame_done"}, 32'(fd_cnt), 32'(exp_fd));
        check({t, "_err"}, 32'(err), 32'(exp_err));
    endtask

    initial begin
        reset = 1'b1;

        // Full 4x2 frame plus one surplus line that must be swallowed silently.
        do_reset("t1");
        vs_words(2);
        line(0, 4, 1'b0, 8'hA0, 1'b1, 1'b1, 2);
        @(negedge clk); #1;
        check("t1_fifo_rd_busy", 32'(fifo_rd), 1);
        line(4, 4, 1'b0, 8'hB0, 1'b1, 1'b0, 2);
        line(0, 4, 1'b0, 8'hC0, 1'b0, 1'b0, 2);
        vs_words(2);
        push(1'b0, 1'b0, 1'b0, 8'h00);
        drain("t1");
        compare("t1", 1, 1'b0);
        if (got_cyc.size() > 0) check("t1_latency", 32'(got_cyc[0]), 32'(mark_cyc));
        else                    check("t1_latency_nowr", 0, 1);
        check("t1_fifo_rd_idle", 32'(fifo_rd), 0);

        // Five pixels on a four-pixel line: last one dropped with error.
        do_reset("t2");
        vs_words(1);
        line(0, 5, 1'b0, 8'h20, 1'b1, 1'b0, 2);
        drain("t2");
        compare("t2", 0, 1'b1);

        // Odd byte count: partial pixel dropped, next line still starts at H_ACT.
        do_reset("t3");
        vs_words(1);
        line(0, 3, 1'b1, 8'h30, 1'b1, 1'b0, 2);
        line(4, 4, 1'b0, 8'h40, 1'b1, 1'b0, 2);
        drain("t3");
        compare("t3", 0, 1'b1);

        // vsync mid-line 1 aborts without frame_done; new frame restarts at 0.
        do_reset("t4");
        vs_words(1);
        line(0, 4, 1'b0, 8'h50, 1'b1, 1'b0, 2);
        line(4, 2, 1'b0, 8'h60, 1'b1, 1'b0, 0);
        vs_words(2);
        line(0, 4, 1'b0, 8'h70, 1'b1, 1'b0, 2);
        line(4, 4, 1'b0, 8'h78, 1'b1, 1'b0, 2);
        vs_words(1);
        push(1'b0, 1'b0, 1'b0, 8'h00);
        drain("t4");
        compare("t4", 1, 1'b1);

        // Reset mid-line: nothing written until the next vsync.
        do_reset("t5");
        vs_words(1);
        line(0, 2, 1'b0, 8'h80, 1'b1, 1'b0, 0);
        drain("t5a");
        check("t5_pre_nwr", 32'(got_a.size()), 2);
        reset = 1'b1;
        push(1'b0, 1'b0, 1'b1, 8'h11);
        push(1'b0, 1'b0, 1'b1, 8'h22);
        push(1'b0, 1'b0, 1'b1, 8'h33);
        @(posedge clk);
        @(negedge clk); #1;
        check("t5_mid_wr_addr", 32'(wr_addr), 0);
        check("t5_mid_wr_data", 32'(wr_data), 0);
        check("t5_mid_wr_en",   32'(wr_en), 0);
        check("t5_mid_fifo_rd", 32'(fifo_rd), 0);
        check("t5_mid_q_held",  32'(q.size()), 3);
        @(posedge clk); #1;
        reset = 1'b0;
        clear_capture();
        push(1'b0, 1'b0, 0, 8'h00);
        drain("t5b");
        check("t5_nosync_nwr", 32'(got_a.size()), 0);
        check("t5_nosync_err", 32'(err), 0);
        vs_words(1);
        line(0, 4, 1'b0, 8'h90, 1'b1, 1'b0, 2);
        line(4, 4, 1'b0, 8'h98, 1'b1, 1'b0, 2);
        vs_words(1);
        drain("t5c");
        compare("t5", 1, 1'b0);

        // Format conversion on a known RGB565 value.
        do_reset("t6");
        vs_words(1);
        push(1'b0, 1'b0, 1'b1, 8'hF8);
        push(1'b0, 1'b0, 1'b1, 8'h1F);
        push(1'b0, 1'b0, 1'b0, 8'h00);
        drain("t6");
        check("t6_nwr", 32'(got_a.size()), 1);
        if (got_d.size() > 0) begin
`ifdef CAM_RGB332_EN
            check("t6_pix", 32'(got_d[0]), 32'h0000_00E3);
`else
            check("t6_pix", 32'(got_d[0]), 32'h0000_F81F);
`endif
            check("t6_addr", 32'(got_a[0]), 0);
        end
        check("t6_err", 32'(err), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
